// File: rtl/sprite_line_drawer_if.sv
// rtl/sprite_line_drawer_if.sv - draw request, pattern fetch and line-buffer write bundle
//
// Purpose: groups the draw_req/draw_done handshake, the pattern-RAM read port
// and the scanline-buffer write port used by sprite_line_drawer.
// Ports (signals):
//   draw_req, col_base[9:0], flip, frame_id[7:0], row_off[3:0]  requester -> drawer
//   draw_done                                                    drawer -> requester
//   pat_addr[15:0] (drawer -> RAM), pat_data[COLOR_W-1:0] (RAM -> drawer)
//   lb_we, lb_addr[9:0], lb_wdata[COLOR_W-1:0]                   drawer -> line buffer
// Modports: slave = drawer side, master = requester/memory side.

interface sprite_line_drawer_if #(
    parameter int COLOR_W = 8
);
    logic               draw_req;
    logic [9:0]         col_base;
    logic               flip;
    logic [7:0]         frame_id;
    logic [3:0]         row_off;
    logic               draw_done;
    logic [15:0]        pat_addr;
    logic [COLOR_W-1:0] pat_data;
    logic               lb_we;
    logic [9:0]         lb_addr;
    logic [COLOR_W-1:0] lb_wdata;

    modport slave (
        input  draw_req, col_base, flip, frame_id, row_off, pat_data,
        output draw_done, pat_addr, lb_we, lb_addr, lb_wdata
    );

    modport master (
        output draw_req, col_base, flip, frame_id, row_off, pat_data,
        input  draw_done, pat_addr, lb_we, lb_addr, lb_wdata
    );
endinterface

// File: rtl/sprite_line_drawer.sv
// rtl/sprite_line_drawer.sv - draws one 16-pixel sprite slice into the scanline buffer
//
// Purpose: on each accepted draw_req, fetches 16 pattern pixels (optionally
// mirrored), drops transparent ones and writes the rest to the line buffer.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    sprite_line_drawer_if.slave (request handshake, pattern read, line-buffer write)
// Optional feature: define SPRITE_CLIP_EN to suppress pixels at x >= LINE_W;
// otherwise line-buffer addresses wrap modulo 1024.

module sprite_line_drawer #(
    parameter int                 LINE_W  = 640,
    parameter int                 COLOR_W = 8,
    parameter logic [COLOR_W-1:0] TRANSP  = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    sprite_line_drawer_if.slave      bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_px;
    logic [3:0]  r_px_d;
    logic        r_valid_d;
    logic [9:0]  r_col_base;
    logic        r_flip;
    logic [7:0]  r_frame_id;
    logic [3:0]  r_row_off;
    logic [15:0] r_pat_addr;

    logic [3:0]  w_px_next;
    logic [3:0]  w_src_next;
    logic        w_in_range;
    logic [9:0]  w_lb_addr;

    // pat_addr is registered one pixel ahead, so the source x for px+1 is
    // computed here; 15-x equals ~x for a 4-bit value.
    assign w_px_next  = r_px + 4'd1;
    assign w_src_next = r_flip ? ~w_px_next : w_px_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_px       <= '0;
            r_px_d     <= '0;
            r_valid_d  <= 1'b0;
            r_col_base <= '0;
            r_flip     <= 1'b0;
            r_frame_id <= '0;
            r_row_off  <= '0;
            r_pat_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid_d <= 1'b0;
                    if (bus.draw_req) begin
                        r_col_base <= bus.col_base;
                        r_flip     <= bus.flip;
                        r_frame_id <= bus.frame_id;
                        r_row_off  <= bus.row_off;
                        r_px       <= '0;
                        r_pat_addr <= {bus.frame_id, bus.row_off, bus.flip ? 4'hF : 4'h0};
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // pat_data for this px arrives next cycle; px_d/valid_d travel with it.
                    r_valid_d <= 1'b1;
                    r_px_d    <= r_px;
                    if (r_px == 4'd15) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_px       <= w_px_next;
                        r_pat_addr <= {r_frame_id, r_row_off, w_src_next};
                    end
                end
                S_DRAIN: begin
                    r_valid_d <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_valid_d <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPRITE_CLIP_EN
    logic [10:0] w_sum;
    assign w_sum      = {1'b0, r_col_base} + {7'd0, r_px_d};
    assign w_in_range = (w_sum < 11'(LINE_W));
    assign w_lb_addr  = w_sum[9:0];
`else
    // Without clipping the buffer absorbs columns past LINE_W; address wraps mod 1024.
    assign w_in_range = 1'b1;
    assign w_lb_addr  = r_col_base + {6'd0, r_px_d};
`endif

    assign bus.draw_done = (r_state == S_IDLE) && !bus.draw_req;
    assign bus.pat_addr  = r_pat_addr;
    assign bus.lb_we     = r_valid_d && (bus.pat_data != TRANSP) && w_in_range;
    assign bus.lb_addr   = w_lb_addr;
    // Gated so the write-data port reads zero whenever no fetch is in flight.
    assign bus.lb_wdata  = r_valid_d ? bus.pat_data : '0;

endmodule

// File: tb/tb_sprite_line_drawer.sv
// tb/tb_sprite_line_drawer.sv - directed scoreboard bench for sprite_line_drawer

module tb_sprite_line_drawer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_line_drawer_if #(.COLOR_W(8)) bus ();

    sprite_line_drawer #(.LINE_W(640), .COLOR_W(8), .TRANSP(8'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] pmem [16];
    always @(posedge clk) bus.pat_data <= pmem[bus.pat_addr[3:0]];

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issues one slice request and checks every cycle up to the return to idle.
    // req2_at: cycle offset for an illegal second request (0 = none).
    // rst_at:  cycle offset at which reset is asserted (0 = none).
    task automatic run_slice(input string name, input logic [9:0] col, input bit flp,
                             input logic [7:0] frm, input logic [3:0] row,
                             input int req2_at, input int rst_at);
        int last_wr_cycle;
        int n_exp;
        int n_wr;
        logic [10:0] a;
        logic [3:0]  src;
        logic [7:0]  d;
        logic [17:0] e;
        bit          keep;

        exp_q.delete();
        n_exp = 0;
        n_wr  = 0;
        last_wr_cycle = (rst_at != 0) ? rst_at : 17;
        for (int px = 0; px < 16; px++) begin
            src = flp ? 4'(15 - px) : 4'(px);
            d   = pmem[src];
            a   = {1'b0, col} + 11'(px);
`ifdef SPRITE_CLIP_EN
            keep = (a < 11'd640);
`else
            keep = 1'b1;
`endif
            if (px + 2 <= last_wr_cycle && d != 8'd0 && keep) begin
                exp_q.push_back({a[9:0], d});
                n_exp++;
            end
        end

        @(negedge clk);
        bus.draw_req = 1'b1;
        bus.col_base = col;
        bus.flip     = flp;
        bus.frame_id = frm;
        bus.row_off  = row;
        #1;
        chk({name, " done_on_req"}, 32'(bus.draw_done), 32'd0);

        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            bus.draw_req = (k == req2_at);
            bus.col_base = 10'h3FF;
            bus.flip     = ~flp;
            bus.frame_id = 8'hEE;
            bus.row_off  = 4'hE;
            #1;
            if (rst_at != 0 && k == rst_at + 1) begin
                chk({name, " we_after_reset"}, 32'(bus.lb_we), 32'd0);
                chk({name, " done_after_reset"}, 32'(bus.draw_done), 32'd1);
                reset = 1'b0;
                exp_q.delete();
                break;
            end
            if (k <= 16) begin
                src = flp ? 4'(16 - k) : 4'(k - 1);
                chk($sformatf("%s pat_addr T+%0d", name, k), 32'(bus.pat_addr), 32'({frm, row, src}));
            end
            if (bus.lb_we) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s unexpected_write T+%0d", name, k), 32'(bus.lb_addr), 32'h7FFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s lb_addr T+%0d", name, k), 32'(bus.lb_addr), 32'(e[17:8]));
                    chk($sformatf("%s lb_wdata T+%0d", name, k), 32'(bus.lb_wdata), 32'(e[7:0]));
                end
            end
            if (k <= 17) chk($sformatf("%s busy T+%0d", name, k), 32'(bus.draw_done), 32'd0);
            else         chk({name, " done_T+18"}, 32'(bus.draw_done), 32'd1);
            if (k == rst_at) reset = 1'b1;
        end
        chk({name, " write_count"}, 32'(n_wr), 32'(n_exp));
        chk({name, " queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.draw_req = 1'b0;
        bus.col_base = '0;
        bus.flip     = 1'b0;
        bus.frame_id = '0;
        bus.row_off  = '0;
        for (int i = 0; i < 16; i++) pmem[i] = 8'(i + 1);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst draw_done", 32'(bus.draw_done), 32'd1);
        chk("rst lb_we", 32'(bus.lb_we), 32'd0);
        chk("rst pat_addr", 32'(bus.pat_addr), 32'd0);
        chk("rst lb_addr", 32'(bus.lb_addr), 32'd0);
        chk("rst lb_wdata", 32'(bus.lb_wdata), 32'd0);
        bus.draw_req = 1'b1;
        #1;
        chk("rst done_with_req", 32'(bus.draw_done), 32'd0);
        @(negedge clk);
        bus.draw_req = 1'b0;
        #1;
        chk("rst still_idle", 32'(bus.draw_done), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Opaque slice, no flip, then flipped
        run_slice("opaque", 10'd100, 1'b0, 8'd3, 4'd5, 0, 0);
        run_slice("flip", 10'd100, 1'b1, 8'd3, 4'd5, 0, 0);

        // Even pattern pixels transparent
        for (int i = 0; i < 16; i++) pmem[i] = (i % 2 == 0) ? 8'd0 : 8'(i + 1);
        run_slice("transp", 10'd100, 1'b0, 8'd3, 4'd5, 0, 0);

        // Right-edge slice, then a slice straddling the 1024 wrap
        for (int i = 0; i < 16; i++) pmem[i] = 8'(8'hA0 + i);
        run_slice("edge", 10'd632, 1'b0, 8'h12, 4'd9, 0, 0);
        run_slice("wrap", 10'd1016, 1'b1, 8'h7F, 4'd0, 0, 0);

        // Illegal second request during busy, then reset mid-slice
        for (int i = 0; i < 16; i++) pmem[i] = 8'(i * 3 + 1);
        run_slice("busy_rst", 10'd200, 1'b0, 8'h44, 4'd2, 5, 8);
        @(negedge clk);
        #1;
        chk("post_rst idle", 32'(bus.draw_done), 32'd1);
        chk("post_rst no_we", 32'(bus.lb_we), 32'd0);

        // Engine works normally after the interrupted slice
        run_slice("recover", 10'd0, 1'b1, 8'hFF, 4'hF, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
